// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the req/ack handshake to
// instruction memory, holds each fetched word until decode accepts it, and
// decodes the immediate field and extension-format select for sign extension.
module instr_fetch_unit #(
   parameter logic [63:0] PC_RESET = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_imem_req,
   output logic [63:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   input  logic        i_stall,
   input  logic        i_br_taken,
   input  logic [63:0] i_br_target,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [63:0] o_pc,
   output logic [25:0] o_address,
   output logic [1:0]  o_seu
);

   typedef enum logic [1:0] {StStart, StFetch, StHold} state_e;

   state_e      r_state;
   logic [63:0] r_fetch_pc;
   logic        r_redir_pend;
   logic [63:0] r_redir_tgt;
   logic [31:0] r_instr;
   logic [63:0] r_pc;

   state_e      w_state_nxt;
   logic [63:0] w_fetch_pc_nxt;
   logic        w_redir_pend_nxt;
   logic [63:0] w_redir_tgt_nxt;
   logic [31:0] w_instr_nxt;
   logic [63:0] w_pc_nxt;
   logic [63:0] w_br_tgt;
   logic [1:0]  w_seu;

   // Branch targets are word aligned; low two bits are dropped on capture.
   assign w_br_tgt = i_br_target & ~64'h3;

   // State and datapath registers; async reset abandons any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StStart;
         r_fetch_pc   <= PC_RESET;
         r_redir_pend <= 1'b0;
         r_redir_tgt  <= 64'h0;
         r_instr      <= 32'h0;
         r_pc         <= 64'h0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_pc   <= w_fetch_pc_nxt;
         r_redir_pend <= w_redir_pend_nxt;
         r_redir_tgt  <= w_redir_tgt_nxt;
         r_instr      <= w_instr_nxt;
         r_pc         <= w_pc_nxt;
      end
   end

   // Next-state logic for the fetch sequencer and its datapath.
   always_comb begin
      w_state_nxt      = r_state;
      w_fetch_pc_nxt   = r_fetch_pc;
      w_redir_pend_nxt = r_redir_pend;
      w_redir_tgt_nxt  = r_redir_tgt;
      w_instr_nxt      = r_instr;
      w_pc_nxt         = r_pc;
      unique case (r_state)
         StStart: begin
            w_state_nxt = StFetch;
         end
         StFetch: begin
            if (i_imem_ack) begin
               if (r_redir_pend || i_br_taken) begin
                  // Response belongs to the abandoned path: drop it and refetch.
                  w_fetch_pc_nxt   = i_br_taken ? w_br_tgt : r_redir_tgt;
                  w_redir_pend_nxt = 1'b0;
               end else begin
                  w_instr_nxt = i_imem_data;
                  w_pc_nxt    = r_fetch_pc;
                  w_state_nxt = StHold;
               end
            end else if (i_br_taken) begin
               // Address must stay stable until ack, so park the redirect.
               w_redir_pend_nxt = 1'b1;
               w_redir_tgt_nxt  = w_br_tgt;
            end
         end
         StHold: begin
            if (i_br_taken) begin
               w_fetch_pc_nxt = w_br_tgt;
               w_state_nxt    = StFetch;
            end else if (!i_stall) begin
               w_fetch_pc_nxt = r_pc + 64'd4;
               w_state_nxt    = StFetch;
            end
         end
         default: begin
            w_state_nxt = StStart;
         end
      endcase
   end

   // Extension-format select; earlier matches take priority.
   always_comb begin
      w_seu = 2'b00;
      if (r_instr[31:26] == 6'b000101) begin
         w_seu = 2'b10;
      end else if (r_instr[31:24] == 8'b10110100 || r_instr[31:24] == 8'b10110101 ||
                   r_instr[31:24] == 8'b01010100) begin
         w_seu = 2'b11;
      end else if (r_instr[31:21] == 11'b11111000000 || r_instr[31:21] == 11'b11111000010) begin
         w_seu = 2'b01;
      end
   end

   assign o_imem_req    = (r_state == StFetch);
   assign o_imem_addr   = r_fetch_pc;
   assign o_instr_valid = (r_state == StHold);
   assign o_instr       = r_instr;
   assign o_pc          = r_pc;
   assign o_address     = r_instr[25:0];
   assign o_seu         = w_seu;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized memory latency, stalls and branches against a flag-based
// transaction model; a second instance checks PC wrap-around.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic        stall;
   logic        br_taken;
   logic [63:0] br_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] pc;
   logic [25:0] address;
   logic [1:0]  seu;

   logic        req2;
   logic [63:0] addr2;
   logic        valid2;
   logic [31:0] instr2;
   logic [63:0] pc2;
   logic [25:0] address2;
   logic [1:0]  seu2;

   int n_checks = 0;
   int n_errors = 0;
   int fixed_lat;
   int lat;
   bit dir_seq;
   int seq_idx;
   int n2;
   logic [63:0] seq_exp [4];

   // Behavioural model state.
   bit          m_started;
   bit          m_req;
   bit          m_held;
   logic [63:0] m_addr;
   logic [31:0] m_instr;
   logic [63:0] m_pc;
   bit          m_redir_v;
   logic [63:0] m_redir_t;

   instr_fetch_unit #(.PC_RESET(64'h0)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ack   (imem_ack),
      .i_imem_data  (imem_data),
      .i_stall      (stall),
      .i_br_taken   (br_taken),
      .i_br_target  (br_target),
      .o_instr_valid(instr_valid),
      .o_instr      (instr),
      .o_pc         (pc),
      .o_address    (address),
      .o_seu        (seu)
   );

   // Zero-wait memory, never stalled: exercises PC wrap from the top of memory.
   instr_fetch_unit #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_wrap (
      .clk          (clk),
      .rst_n        (rst_n),
      .o_imem_req   (req2),
      .o_imem_addr  (addr2),
      .i_imem_ack   (req2),
      .i_imem_data  (32'h9100_0400),
      .i_stall      (1'b0),
      .i_br_taken   (1'b0),
      .i_br_target  (64'h0),
      .o_instr_valid(valid2),
      .o_instr      (instr2),
      .o_pc         (pc2),
      .o_address    (address2),
      .o_seu        (seu2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_word(logic [63:0] a);
      logic [3:0] h;
      h = a[5:2] ^ a[13:10];
      case (a)
         64'h0:   return 32'h1400_0010;
         64'h4:   return 32'hF840_0000;
         64'h8:   return 32'hB400_0040;
         64'hC:   return 32'h9100_0400;
         default: begin
            case (h[2:0])
               3'd0: return {6'b000101, a[27:2]};
               3'd1: return {8'hB4, a[25:2]};
               3'd2: return {8'hB5, a[25:2]};
               3'd3: return {8'h54, a[25:2]};
               3'd4: return {11'b11111000000, a[22:2]};
               3'd5: return {11'b11111000010, a[22:2]};
               3'd6: return {10'b1001000100, a[23:2]};
               default: return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
            endcase
         end
      endcase
   endfunction

   // Sign-extend format by instruction class.
   function automatic logic [1:0] model_seu(logic [31:0] i);
      if (i[31:26] == 6'b000101) return 2'b10;
      if (i[31:24] == 8'hB4 || i[31:24] == 8'hB5 || i[31:24] == 8'h54) return 2'b11;
      if (i[31:21] == 11'h7C0 || i[31:21] == 11'h7C2) return 2'b01;
      return 2'b00;
   endfunction

   // Memory responder: picks a latency per request, answers with a word
   // derived from the address.
   always @(posedge clk) begin
      #1;
      if (!rst_n || !imem_req) begin
         lat = -1;
         imem_ack = 1'b0;
      end else begin
         if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
         if (lat == 0) begin
            imem_ack  = 1'b1;
            imem_data = mem_word(imem_addr);
            lat = -1;
         end else begin
            imem_ack  = 1'b0;
            imem_data = $urandom;
            lat--;
         end
      end
   end

   // Transaction model: one outstanding fetch or one held word, plus a parked redirect.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_started <= 1'b0;
         m_req     <= 1'b0;
         m_held    <= 1'b0;
         m_addr    <= 64'h0;
         m_instr   <= 32'h0;
         m_pc      <= 64'h0;
         m_redir_v <= 1'b0;
         m_redir_t <= 64'h0;
      end else if (!m_started) begin
         m_started <= 1'b1;
         m_req     <= 1'b1;
      end else if (m_req) begin
         if (imem_ack) begin
            if (m_redir_v || br_taken) begin
               m_addr    <= br_taken ? {br_target[63:2], 2'b00} : m_redir_t;
               m_redir_v <= 1'b0;
            end else begin
               m_req   <= 1'b0;
               m_held  <= 1'b1;
               m_instr <= imem_data;
               m_pc    <= m_addr;
            end
         end else if (br_taken) begin
            m_redir_v <= 1'b1;
            m_redir_t <= {br_target[63:2], 2'b00};
         end
      end else if (m_held) begin
         if (br_taken) begin
            m_held <= 1'b0;
            m_req  <= 1'b1;
            m_addr <= {br_target[63:2], 2'b00};
         end else if (!stall) begin
            m_held <= 1'b0;
            m_req  <= 1'b1;
            m_addr <= m_pc + 64'd4;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("req", {63'h0, imem_req}, {63'h0, m_req});
         check("imem_addr", imem_addr, m_addr);
         check("instr_valid", {63'h0, instr_valid}, {63'h0, m_held});
         check("instr", {32'h0, instr}, {32'h0, m_instr});
         check("pc", pc, m_pc);
         check("address", {38'h0, address}, {38'h0, m_instr[25:0]});
         check("seu", {62'h0, seu}, {62'h0, model_seu(m_instr)});
      end
   end

   // Literal pins during the opening sequential fetch run.
   always @(negedge clk) begin
      if (rst_n && dir_seq) begin
         if (imem_req && imem_ack && seq_idx < 4) begin
            check("seq_addr", imem_addr, seq_exp[seq_idx]);
            seq_idx++;
         end
         if (instr_valid) begin
            case (pc)
               64'h0: check("seu_b", {62'h0, seu}, 64'd2);
               64'h4: check("seu_ldur", {62'h0, seu}, 64'd1);
               64'h8: check("seu_cbz", {62'h0, seu}, 64'd3);
               64'hC: check("seu_addi", {62'h0, seu}, 64'd0);
               default: check("seq_pc", pc, 64'hC);
            endcase
         end
      end
   end

   // Wrap instance: first two fetch addresses.
   always @(negedge clk) begin
      if (rst_n && req2 && n2 < 2) begin
         check("wrap_addr", addr2, (n2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h0);
         n2++;
      end
   end

   initial begin
      int t;
      seq_exp[0] = 64'h0; seq_exp[1] = 64'h4; seq_exp[2] = 64'h8; seq_exp[3] = 64'hC;
      seq_idx = 0; n2 = 0; lat = -1;
      rst_n = 1'b0; stall = 1'b1; br_taken = 1'b0; br_target = 64'h0;
      imem_ack = 1'b0; imem_data = 32'h0; fixed_lat = 1; dir_seq = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_req", {63'h0, imem_req}, 64'h0);
      check("rst_addr", imem_addr, 64'h0);
      check("rst_valid", {63'h0, instr_valid}, 64'h0);
      check("rst_instr", {32'h0, instr}, 64'h0);
      check("rst_seu", {62'h0, seu}, 64'h0);
      check("rst_addr_wrap", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("start_req", {63'h0, imem_req}, 64'h0);
      @(negedge clk);
      check("first_req", {63'h0, imem_req}, 64'h1);

      // Stalled hold of the B instruction.
      t = 0;
      while (!instr_valid && t < 20) begin @(negedge clk); t++; end
      check("wait_valid0", {63'h0, instr_valid}, 64'h1);
      repeat (5) begin
         check("hold_valid", {63'h0, instr_valid}, 64'h1);
         check("hold_pc", pc, 64'h0);
         check("hold_address", {38'h0, address}, 64'h10);
         check("hold_req", {63'h0, imem_req}, 64'h0);
         @(negedge clk);
      end
      stall = 1'b0;

      t = 0;
      while (!(instr_valid && pc == 64'hC) && t < 40) begin @(negedge clk); t++; end
      check("wait_pc_c", pc, 64'hC);
      dir_seq = 1'b0;
      fixed_lat = 3;

      // Redirect during a slow fetch.
      @(negedge clk);
      check("fetch_10", imem_addr, 64'h10);
      br_taken = 1'b1; br_target = 64'h103;
      @(negedge clk);
      br_taken = 1'b0;
      t = 0;
      while (!imem_ack && t < 20) begin
         check("redir_no_valid", {63'h0, instr_valid}, 64'h0);
         @(negedge clk); t++;
      end
      check("wait_ack", {63'h0, imem_ack}, 64'h1);
      @(negedge clk);
      check("redir_addr", imem_addr, 64'h100);
      check("redir_valid", {63'h0, instr_valid}, 64'h0);
      t = 0;
      while (!instr_valid && t < 20) begin @(negedge clk); t++; end
      check("redir_pc", pc, 64'h100);

      // Branch coinciding with an ack.
      fixed_lat = 0;
      @(negedge clk);
      check("same_ack", {62'h0, imem_req, imem_ack}, 64'h3);
      br_taken = 1'b1; br_target = 64'h200;
      @(negedge clk);
      br_taken = 1'b0;
      check("same_addr", imem_addr, 64'h200);
      check("same_valid", {63'h0, instr_valid}, 64'h0);
      @(negedge clk);
      check("same_pc", {pc[62:0], instr_valid}, {63'h200, 1'b1});

      // Randomized traffic.
      fixed_lat = -1;
      repeat (3000) begin
         @(negedge clk);
         stall     = ($urandom_range(0, 9) < 3);
         br_taken  = ($urandom_range(0, 9) == 0);
         br_target = ($urandom_range(0, 1) == 0) ? {32'h0, 20'h0, 12'($urandom)}
                                                 : {$urandom, $urandom};
      end
      @(negedge clk);
      br_taken = 1'b0; stall = 1'b0;

      // Asynchronous reset while a request is outstanding.
      t = 0;
      while (!imem_req && t < 20) begin @(negedge clk); t++; end
      check("wait_req", {63'h0, imem_req}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_req", {63'h0, imem_req}, 64'h0);
      check("async_addr", imem_addr, 64'h0);
      check("async_valid", {63'h0, instr_valid}, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      t = 0;
      @(negedge clk);
      while (!imem_req && t < 20) begin @(negedge clk); t++; end
      check("restart_addr", {imem_addr[62:0], imem_req}, {63'h0, 1'b1});

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
